// File: rtl/bisr_reader_pkg.sv
// rtl/bisr_reader_pkg.sv - shared types and sizing helpers for the result reader
package bisr_reader_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} reader_state_t;

    // One slot per read that can be in flight, plus one for the row being unpacked.
    function automatic int fifo_depth(input int access_latency);
        return access_latency + 1;
    endfunction

endpackage

// File: rtl/result_row_fifo.sv
// rtl/result_row_fifo.sv - synchronous row FIFO between RAM return path and unpacker
module result_row_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/matmul_result_reader.sv
// rtl/matmul_result_reader.sv - drains the result matrix from output RAM as a per-element stream
module matmul_result_reader
    import bisr_reader_pkg::*;
#(
    parameter int          ROWS               = 4,
    parameter int          COLS               = 4,
    parameter int          WORD_SIZE          = 8,
    parameter int          MEM_PORT_WIDTH     = 32,
    parameter int          MEM_ACCESS_LATENCY = 2,
    parameter logic [31:0] BASE_ADDR          = 32'h0,
    localparam int         ROW_W              = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int         COL_W              = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               mem_addr,
    output logic                      mem_rd_en,
    input  logic [MEM_PORT_WIDTH-1:0] mem_rd_data,
    output logic [WORD_SIZE-1:0]      out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ROW_W-1:0]          out_row,
    output logic [COL_W-1:0]          out_col,
    output logic                      out_last
);

    localparam int DEPTH    = fifo_depth(MEM_ACCESS_LATENCY);
    localparam int CNT_W    = $clog2(DEPTH + 1);
    localparam int ROW_BITS = COLS * WORD_SIZE;

    reader_state_t                 state;
    reader_state_t                 state_next;
    logic [ROW_W-1:0]              rd_row;
    logic [CNT_W-1:0]              inflight;
    logic [MEM_ACCESS_LATENCY-1:0] rd_pipe;
    logic [CNT_W-1:0]              fifo_count;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [ROW_BITS-1:0]           head;
    logic                          credit_ok;
    logic                          issue;
    logic                          push;
    logic                          pop;
    logic                          handshake;
    logic                          row_end;
    logic                          unused_rd_bits;

    // Rows already buffered plus rows still travelling through the RAM must fit the FIFO.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < (CNT_W + 1)'(DEPTH);
    assign issue     = (state == ISSUE) && credit_ok;
    assign push      = rd_pipe[MEM_ACCESS_LATENCY-1];
    assign mem_rd_en = issue;
    assign mem_addr  = issue ? (BASE_ADDR + 32'(rd_row)) : 32'h0;

    assign out_valid = !fifo_empty;
    assign handshake = out_valid && out_ready;
    assign row_end   = (out_col == COL_W'(COLS - 1));
    assign pop       = handshake && row_end;
    assign out_data  = out_valid ? head[int'(out_col) * WORD_SIZE +: WORD_SIZE] : '0;
    assign out_last  = out_valid && row_end && (out_row == ROW_W'(ROWS - 1));

    assign unused_rd_bits = ^mem_rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                busy = 1'b1;
                if (issue && rd_row == ROW_W'(ROWS - 1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (handshake && out_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            rd_row <= '0;
        end else if (issue) begin
            rd_row <= rd_row + ROW_W'(1);
        end
    end

    // Valid bits march alongside the RAM pipeline; clearing them on reset drops late returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pipe  <= '0;
            inflight <= '0;
        end else begin
            rd_pipe[0] <= issue;
            for (int i = 1; i < MEM_ACCESS_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            case ({issue, push})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_col <= '0;
            out_row <= '0;
        end else begin
            if (handshake) begin
                out_col <= row_end ? '0 : out_col + COL_W'(1);
            end
            if (pop) begin
                out_row <= (out_row == ROW_W'(ROWS - 1)) ? '0 : out_row + ROW_W'(1);
            end
        end
    end

    result_row_fifo #(
        .WIDTH (ROW_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (mem_rd_data[ROW_BITS-1:0]),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule

// File: tb/tb_matmul_result_reader.sv
// tb/tb_matmul_result_reader.sv - scoreboard bench over three read latencies (2, 1, 4)
module tb_matmul_result_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic out_ready = 1'b0;

    always #5 clk = ~clk;

    logic [2:0]  busy_a, done_a, rd_en_a, valid_a, last_a;
    logic [31:0] addr_a  [3];
    logic [31:0] rdata_a [3];
    logic [7:0]  data_a  [3];
    logic [1:0]  row_a   [3];
    logic [1:0]  col_a   [3];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    logic [12:0] exp_q [3][$];
    int beats [3];
    int done_cnt [3];
    int reads [3];
    int bad_rd [3];
    int outstanding [3];
    int rise_cyc [3];
    int read_cnt [3][4];
    logic pv [3];
    logic pr [3];
    logic lh [3];
    logic [12:0] pitem [3];

    function automatic int lat_of(input int l);
        return (l == 0) ? 2 : (l == 1) ? 1 : 4;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        int r;
        w = 32'hDEAD_BEEF;
        if (a >= 32'h100 && a < 32'h104) begin
            r = int'(a - 32'h100);
            for (int c = 0; c < 4; c++) w[c*8 +: 8] = 8'(16 * r + c);
        end
        return w;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_lane
        localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 4;
        logic [31:0] ap [8];

        always @(posedge clk) begin
            ap[0] <= rd_en_a[g] ? addr_a[g] : 32'hFFFF_FFFF;
            for (int i = 1; i < 8; i++) ap[i] <= ap[i-1];
        end
        assign rdata_a[g] = mem_word(ap[L-1]);

        matmul_result_reader #(
            .ROWS(4), .COLS(4), .WORD_SIZE(8), .MEM_PORT_WIDTH(32),
            .MEM_ACCESS_LATENCY(L), .BASE_ADDR(32'h100)
        ) u_dut (
            .clk(clk), .rst(rst), .start(start),
            .busy(busy_a[g]), .done(done_a[g]),
            .mem_addr(addr_a[g]), .mem_rd_en(rd_en_a[g]), .mem_rd_data(rdata_a[g]),
            .out_data(data_a[g]), .out_valid(valid_a[g]), .out_ready(out_ready),
            .out_row(row_a[g]), .out_col(col_a[g]), .out_last(last_a[g])
        );
    end

    always @(negedge clk) begin : monitor
        logic [12:0] cur;
        logic [12:0] e;
        logic hs;
        for (int l = 0; l < 3; l++) begin
            if (rst) begin
                outstanding[l] = 0;
                pv[l] = 1'b0;
                pr[l] = 1'b0;
                lh[l] = 1'b0;
            end else begin
                cur = {last_a[l], row_a[l], col_a[l], data_a[l]};
                if (rd_en_a[l]) begin
                    reads[l]++;
                    if (addr_a[l] >= 32'h100 && addr_a[l] < 32'h104) read_cnt[l][int'(addr_a[l] - 32'h100)]++;
                    else bad_rd[l]++;
                    chk("credit_bound", 32'(outstanding[l] + 1 <= lat_of(l) + 1), 32'd1);
                    outstanding[l]++;
                end
                if (pv[l] && !pr[l] && valid_a[l]) chk("hold_stable", 32'(cur), 32'(pitem[l]));
                if (done_a[l]) begin
                    chk("done_after_last", 32'(lh[l]), 32'd1);
                    done_cnt[l]++;
                end
                if (valid_a[l] && !pv[l]) rise_cyc[l] = cyc;
                hs = valid_a[l] && out_ready;
                if (hs) begin
                    beats[l]++;
                    if (exp_q[l].size() == 0) begin
                        chk("unexpected_beat", 32'(cur), 32'h1FFF);
                    end else begin
                        e = exp_q[l].pop_front();
                        chk("beat", 32'(cur), 32'(e));
                    end
                    if (col_a[l] == 2'd3) outstanding[l]--;
                end
                lh[l] = hs && last_a[l];
                pv[l] = valid_a[l];
                pr[l] = out_ready;
                pitem[l] = cur;
            end
        end
    end

    task automatic push_drain();
        for (int l = 0; l < 3; l++)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    exp_q[l].push_back({(r == 3 && c == 3), 2'(r), 2'(c), 8'(16 * r + c)});
    endtask

    task automatic pulse_start(output int t);
        @(posedge clk);
        #1 start = 1'b1;
        t = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int target, input bit rnd);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 3000) begin
            @(posedge clk);
            #1;
            if (rnd) out_ready = ($urandom_range(0, 9) >= 3);
            n++;
            ok = (done_cnt[0] >= target) && (done_cnt[1] >= target) && (done_cnt[2] >= target);
        end
        chk("drain_completes", 32'(ok), 32'd1);
    endtask

    task automatic chk_reset();
        for (int l = 0; l < 3; l++) begin
            chk("rst_busy", 32'(busy_a[l]), 32'd0);
            chk("rst_done", 32'(done_a[l]), 32'd0);
            chk("rst_rd_en", 32'(rd_en_a[l]), 32'd0);
            chk("rst_addr", addr_a[l], 32'd0);
            chk("rst_valid", 32'(valid_a[l]), 32'd0);
            chk("rst_data", 32'(data_a[l]), 32'd0);
            chk("rst_row", 32'(row_a[l]), 32'd0);
            chk("rst_col", 32'(col_a[l]), 32'd0);
            chk("rst_last", 32'(last_a[l]), 32'd0);
        end
    endtask

    task automatic check_reads_once(input int snap [3][4]);
        for (int l = 0; l < 3; l++) begin
            for (int a = 0; a < 4; a++) chk("read_once", 32'(read_cnt[l][a] - snap[l][a]), 32'd1);
            chk("bad_addr", 32'(bad_rd[l]), 32'd0);
            chk("queue_empty", 32'(exp_q[l].size()), 32'd0);
        end
    endtask

    initial begin
        int t;
        int n;
        int b0;
        bit seen;
        int snap [3][4];
        int rsnap [3];

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset();
        @(posedge clk);
        #1 rst = 1'b0;

        // free-flowing drain with first-valid latency per lane
        out_ready = 1'b1;
        push_drain();
        snap = read_cnt;
        pulse_start(t);
        for (int l = 0; l < 3; l++) chk("busy_after_start", 32'(busy_a[l]), 32'd1);
        wait_done(1, 1'b0);
        for (int l = 0; l < 3; l++) chk("first_valid_cycle", 32'(rise_cyc[l]), 32'(t + 2 + lat_of(l)));
        check_reads_once(snap);

        // random backpressure
        push_drain();
        pulse_start(t);
        wait_done(2, 1'b1);
        for (int l = 0; l < 3; l++) chk("queue_empty_bp", 32'(exp_q[l].size()), 32'd0);

        // full stall: reads capped by FIFO depth, head element held
        out_ready = 1'b0;
        push_drain();
        rsnap = reads;
        pulse_start(t);
        repeat (50) @(posedge clk);
        @(negedge clk);
        for (int l = 0; l < 3; l++) begin
            chk("stall_reads", 32'(reads[l] - rsnap[l]), 32'((lat_of(l) + 1 < 4) ? lat_of(l) + 1 : 4));
            chk("stall_valid", 32'(valid_a[l]), 32'd1);
            chk("stall_data", 32'(data_a[l]), 32'h00);
            chk("stall_rowcol", 32'({row_a[l], col_a[l]}), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done(3, 1'b0);

        // second start mid-drain is ignored
        push_drain();
        pulse_start(t);
        repeat (8) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(4, 1'b0);
        repeat (30) @(posedge clk);
        @(negedge clk);
        for (int l = 0; l < 3; l++) begin
            chk("single_done", 32'(done_cnt[l]), 32'd4);
            chk("idle_after_drain", 32'(busy_a[l]), 32'd0);
            chk("queue_empty_busy", 32'(exp_q[l].size()), 32'd0);
        end

        // reset after 5 beats on lane 0
        push_drain();
        pulse_start(t);
        b0 = beats[0];
        n = 0;
        while (beats[0] < b0 + 5 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reached_5_beats", 32'(beats[0] >= b0 + 5), 32'd1);
        rst = 1'b1;
        for (int l = 0; l < 3; l++) exp_q[l].delete();
        @(posedge clk);
        @(negedge clk);
        chk_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (|valid_a) seen = 1'b1;
        end
        chk("late_data_dropped", 32'(seen), 32'd0);
        for (int l = 0; l < 3; l++) chk("no_done_on_reset", 32'(done_cnt[l]), 32'd4);

        push_drain();
        snap = read_cnt;
        pulse_start(t);
        wait_done(5, 1'b0);
        check_reads_once(snap);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matmul_result_reader.md
# matmul_result_reader

Drains a completed result matrix from the output RAM, which is written by the matmul output controller, and streams it to the host one element per beat over a valid/ready interface. It is the read-side counterpart of the output-RAM write path. It issues fixed-latency memory reads and buffers returning rows so that host backpressure never loses data. It unpacks each row word into COLS elements in column order.

## Interface
Parameters:
- ROWS, `ROWS: result matrix rows; one output-RAM word per row.
- COLS, `COLS: elements per row word.
- WORD_SIZE, `WORD_SIZE: element width in bits.
- MEM_PORT_WIDTH, `MEM_PORT_WIDTH: RAM data width; must be ≥ COLS*WORD_SIZE.
- MEM_ACCESS_LATENCY, `MEM_ACCESS_LATENCY: cycles from address and read-enable to valid rd_data; must be ≥ 1.
- BASE_ADDR, 0: address of row 0.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that begins a drain. It is ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last element handshakes.
- mem_addr  out  32  output-RAM read address.
- mem_rd_en  out  1  read strobe; one row per asserted cycle.
- mem_rd_data  in  MEM_PORT_WIDTH  read data, valid exactly MEM_ACCESS_LATENCY cycles after mem_rd_en.
- out_data  out  WORD_SIZE  current element.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  host accepts the element.
- out_row  out  $clog2(ROWS)  row index of out_data.
- out_col  out  $clog2(COLS)  column index of out_data.
- out_last  out  1  high with the element (ROWS-1, COLS-1).

## Operation
State machine states: IDLE, ISSUE, DRAIN, DONE.
- IDLE → ISSUE on start.
- ISSUE → DRAIN after row ROWS-1 is issued.
- DRAIN → DONE on the out_last handshake.
- DONE → IDLE after one cycle; done=1 in DONE.

Read issue rules:
- In ISSUE, mem_rd_en=1 and mem_addr=BASE_ADDR+rd_row only when credits allow: (FIFO occupancy + reads in flight) < FIFO_DEPTH.
- FIFO_DEPTH = MEM_ACCESS_LATENCY+1.
- rd_row increments on each issue.

Return capture:
- A MEM_ACCESS_LATENCY-deep shift register of valid bits tracks reads in flight.
- When a valid bit exits, mem_rd_data[COLS*WORD_SIZE-1:0] is pushed into the FIFO.
- Bits above COLS*WORD_SIZE are ignored.

Unpacker:
- Holds the FIFO head row.
- out_data = head[col*WORD_SIZE +: WORD_SIZE], so column 0 is the LSBs.
- out_valid is high while the FIFO is non-empty.
- On handshake (out_valid & out_ready), col increments.
- At col = COLS-1, the FIFO pops, col resets to 0 and out_row increments.

General rules:
- Elements are passed through unchanged; no arithmetic or sign handling.
- A push and a pop in the same cycle are legal; occupancy is unchanged.
- The credit rule guarantees the FIFO never overflows, so a push into a full FIFO is impossible by construction. An assertion checks this.

## Timing
Reset values: busy=0, done=0, mem_rd_en=0, mem_addr=0, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0. Reset also clears the FIFO, all in-flight valid bits and all counters.

Latency and throughput:
- First element: start at cycle T; first mem_rd_en at T+1; out_valid at T+1+MEM_ACCESS_LATENCY+1.
- With out_ready held high, one element is produced per cycle and there are no bubbles between rows, provided COLS ≥ 2 or the FIFO is deep enough.
- Drain length with out_ready=1: ROWS*COLS beats, plus fill latency.

Handshake rules:
- Once out_valid is asserted, out_data, out_row, out_col and out_last stay stable until accepted.
- out_ready may toggle freely.

Boundary conditions:
- start while busy: ignored; no state change.
- start in the same cycle as done: ignored. A new drain requires start in IDLE.
- Reset mid-drain: next cycle all outputs hold reset values. Read data returning afterwards is discarded because the in-flight bits are cleared. No done pulse is produced.
- out_ready=0 for the whole drain: issue stops after FIFO_DEPTH rows; no data is lost.
- ROWS=1: ISSUE lasts one cycle; DRAIN then emits COLS beats.

## Structure
- Package bisr_reader_pkg holds:
  - the state enum `reader_state_t` {IDLE, ISSUE, DRAIN, DONE};
  - a function for FIFO_DEPTH derived from MEM_ACCESS_LATENCY.
- Sub-module result_row_fifo: synchronous FIFO, COLS*WORD_SIZE wide, FIFO_DEPTH deep, with push, pop, full, empty and count ports. It is reset by rst.
- The top contains the FSM, credit counter, latency valid pipe and unpacker.

## Test plan
Default configuration: ROWS=COLS=4, WORD_SIZE=8, MEM_ACCESS_LATENCY=2, BASE_ADDR=0x100, RAM preloaded with element (r,c) = 16r+c.
- Free-flowing drain: out_ready=1, start pulse → 16 beats with values 0x00,0x01,…,0x33 in row-major order; out_last only on 0x33; done pulses 1 cycle later; addresses 0x100–0x103 each read exactly once.
- Random backpressure: out_ready driven 30% random → identical sequence with no drops or duplicates; FIFO count never exceeds 3; out_data stays stable while out_valid=1 and out_ready=0.
- Full stall: out_ready=0 for 50 cycles after start → exactly 3 reads issued, out_valid=1 holding 0x00; on release, all 16 elements arrive.
- Start while busy: second start pulse mid-drain → ignored; exactly 16 beats and one done pulse.
- Reset mid-drain: rst after 5 beats → all outputs at reset values next cycle, late read data discarded; a new start yields a full, correct 16-beat drain.
- Latency sweep: MEM_ACCESS_LATENCY ∈ {1,4} → correct data order, with out_valid first asserted at T+2+latency.
